// File: rtl/traffic_controller_param_if.sv
// Lamp/timebase bus between the traffic controller and its surroundings.
// master drives tick/flash/ped_req; slave (the controller) drives lamps and status.
interface traffic_controller_param_if #(
    parameter int CNT_W = 4
);
    logic             tick;
    logic             flash;
    logic             ped_req;
    logic [2:0]       pole1;
    logic [2:0]       pole2;
    logic [CNT_W-1:0] count;
    logic [2:0]       phase;
    logic             walk;

    modport master (
        output tick, flash, ped_req,
        input  pole1, pole2, count, phase, walk
    );

    modport slave (
        input  tick, flash, ped_req,
        output pole1, pole2, count, phase, walk
    );
endinterface

// File: rtl/traffic_controller_param.sv
// Two-pole intersection controller with all-red clearance and flashing-yellow mode.
// Optional pedestrian green truncation is enabled by defining TRAFFIC_PED_REQ_EN.
//
// state     | meaning
// P2_GREEN  | pole2 green, pole1 red
// P2_YELLOW | pole2 yellow, pole1 red
// CLR_A     | all red after pole2 yellow
// P1_GREEN  | pole1 green, pole2 red
// P1_YELLOW | pole1 yellow, pole2 red
// CLR_B     | all red after pole1 yellow (also the exit path from FLASH)
// FLASH     | both poles blink yellow on count[0]
module traffic_controller_param #(
    parameter int GREEN_TICKS  = 10,
    parameter int YELLOW_TICKS = 4,
    parameter int CLEAR_TICKS  = 2,
    parameter int MIN_GREEN    = 3,
    parameter int CNT_W        = 4
) (
    input logic                         clk_in,
    input logic                         rst_n,
    traffic_controller_param_if.slave   bus
);
    typedef enum logic [2:0] {
        P2_GREEN  = 3'd0,
        P2_YELLOW = 3'd1,
        CLR_A     = 3'd2,
        P1_GREEN  = 3'd3,
        P1_YELLOW = 3'd4,
        CLR_B     = 3'd5,
        FLASH     = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(CLEAR_TICKS - 1);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt, w_last;
    logic [2:0]       r_pole1, r_pole2, w_pole1_nxt, w_pole2_nxt;
    logic             w_is_green;
    logic             w_trunc;

    assign w_is_green = (r_state == P2_GREEN) || (r_state == P1_GREEN);

    always_comb begin
        w_last = G_LAST;
        case (r_state)
            P2_YELLOW, P1_YELLOW: w_last = Y_LAST;
            CLR_A, CLR_B:         w_last = C_LAST;
            default:              w_last = G_LAST;
        endcase
    end

    // flash is checked first so it overrides both expiry and truncation
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (bus.tick) begin
            if (bus.flash) begin
                w_state_nxt = FLASH;
                w_count_nxt = (r_state == FLASH) ? r_count + 1'b1 : '0;
            end else if (r_state == FLASH) begin
                w_state_nxt = CLR_B;
                w_count_nxt = '0;
            end else if ((r_count == w_last) || w_trunc) begin
                w_count_nxt = '0;
                case (r_state)
                    P2_GREEN:  w_state_nxt = P2_YELLOW;
                    P2_YELLOW: w_state_nxt = CLR_A;
                    CLR_A:     w_state_nxt = P1_GREEN;
                    P1_GREEN:  w_state_nxt = P1_YELLOW;
                    P1_YELLOW: w_state_nxt = CLR_B;
                    default:   w_state_nxt = P2_GREEN;
                endcase
            end else begin
                w_count_nxt = r_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_pole1_nxt = 3'b100;
        w_pole2_nxt = 3'b100;
        case (w_state_nxt)
            P2_GREEN:  w_pole2_nxt = 3'b001;
            P2_YELLOW: w_pole2_nxt = 3'b010;
            P1_GREEN:  w_pole1_nxt = 3'b001;
            P1_YELLOW: w_pole1_nxt = 3'b010;
            FLASH: begin
                w_pole1_nxt = w_count_nxt[0] ? 3'b000 : 3'b010;
                w_pole2_nxt = w_count_nxt[0] ? 3'b000 : 3'b010;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state <= P2_GREEN;
            r_count <= '0;
            r_pole1 <= 3'b100;
            r_pole2 <= 3'b001;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_pole1 <= w_pole1_nxt;
            r_pole2 <= w_pole2_nxt;
        end
    end

`ifdef TRAFFIC_PED_REQ_EN
    logic r_ped_pending, w_ped_pending_nxt;
    logic r_walk_due, w_walk_due_nxt;
    logic r_walk, w_walk_nxt;

    assign w_trunc = w_is_green && r_ped_pending && (r_count >= MIN_LAST);

    // a press on the CLR entry edge survives so it arms the next green
    always_comb begin
        w_ped_pending_nxt = r_ped_pending | bus.ped_req;
        w_walk_due_nxt    = r_walk_due;
        w_walk_nxt        = r_walk;
        if (bus.tick) begin
            if (bus.flash && (r_state != FLASH)) begin
                w_ped_pending_nxt = 1'b0;
                w_walk_due_nxt    = 1'b0;
                w_walk_nxt        = 1'b0;
            end else if (w_state_nxt != r_state) begin
                w_walk_nxt = 1'b0;
                if (w_trunc) begin
                    w_walk_due_nxt = 1'b1;
                end
                if ((w_state_nxt == CLR_A) || (w_state_nxt == CLR_B)) begin
                    w_walk_nxt        = r_walk_due;
                    w_walk_due_nxt    = 1'b0;
                    w_ped_pending_nxt = bus.ped_req;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_ped_pending <= 1'b0;
            r_walk_due    <= 1'b0;
            r_walk        <= 1'b0;
        end else begin
            r_ped_pending <= w_ped_pending_nxt;
            r_walk_due    <= w_walk_due_nxt;
            r_walk        <= w_walk_nxt;
        end
    end

    assign bus.walk = r_walk;
`else
    logic w_unused_ped;

    assign w_trunc      = 1'b0;
    assign w_unused_ped = bus.ped_req;
    assign bus.walk     = 1'b0;
`endif

    assign bus.pole1 = r_pole1;
    assign bus.pole2 = r_pole2;
    assign bus.count = r_count;
    assign bus.phase = r_state;
endmodule

// File: tb/tb_traffic_controller_param.sv
// Directed table-driven bench for traffic_controller_param (default parameters).
// Pedestrian expectations follow whether TRAFFIC_PED_REQ_EN is defined.
module tb_traffic_controller_param;
    logic clk_in = 1'b0;
    logic rst_n;

    traffic_controller_param_if #(.CNT_W(4)) bus ();

    traffic_controller_param #(
        .GREEN_TICKS (10),
        .YELLOW_TICKS(4),
        .CLEAR_TICKS (2),
        .MIN_GREEN   (3),
        .CNT_W       (4)
    ) dut (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit         tk;
        bit         fl;
        logic [2:0] ph;
        logic [3:0] cnt;
        logic [2:0] p1;
        logic [2:0] p2;
    } vec_t;

    vec_t vq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int         lens[6] = '{10, 4, 2, 10, 4, 2};
    logic [2:0] lp1[6]  = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [2:0] lp2[6]  = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};

    task automatic step(input bit t, input bit f, input bit p, input bit r);
        bus.tick    = t;
        bus.flash   = f;
        bus.ped_req = p;
        rst_n       = r;
        @(posedge clk_in);
        #1;
    endtask

    task automatic ticks(input int n, input bit f);
        for (int i = 0; i < n; i++) step(1'b1, f, 1'b0, 1'b1);
    endtask

    task automatic chk(input string nm, input logic [2:0] ph, input logic [3:0] c,
                       input logic [2:0] p1, input logic [2:0] p2, input logic w);
        n_tests++;
        if ({bus.phase, bus.count, bus.pole1, bus.pole2, bus.walk} !== {ph, c, p1, p2, w}) begin
            n_fail++;
            $display("FAIL %s: got phase=%0d count=%0d pole1=%b pole2=%b walk=%b, want phase=%0d count=%0d pole1=%b pole2=%b walk=%b",
                     nm, bus.phase, bus.count, bus.pole1, bus.pole2, bus.walk, ph, c, p1, p2, w);
        end
    endtask

    task automatic do_reset(input string nm);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk(nm, 3'd0, 4'd0, 3'b100, 3'b001, 1'b0);
    endtask

    initial begin
        int   nk, nc, pk, pc;
        vec_t v;

        bus.tick = 1'b0; bus.flash = 1'b0; bus.ped_req = 1'b0; rst_n = 1'b0;

        // continuous ticks: one full cycle
        for (int k = 0; k < 6; k++)
            for (int i = 0; i < lens[k]; i++) begin
                nk = (i == lens[k] - 1) ? (k + 1) % 6 : k;
                nc = (i == lens[k] - 1) ? 0 : i + 1;
                vq.push_back('{tk: 1'b1, fl: 1'b0, ph: 3'(nk), cnt: 4'(nc), p1: lp1[nk], p2: lp2[nk]});
            end
        // tick every third clock: two frozen clocks before each tick
        pk = 0; pc = 0;
        for (int k = 0; k < 6; k++)
            for (int i = 0; i < lens[k]; i++) begin
                for (int h = 0; h < 2; h++)
                    vq.push_back('{tk: 1'b0, fl: 1'b0, ph: 3'(pk), cnt: 4'(pc), p1: lp1[pk], p2: lp2[pk]});
                nk = (i == lens[k] - 1) ? (k + 1) % 6 : k;
                nc = (i == lens[k] - 1) ? 0 : i + 1;
                vq.push_back('{tk: 1'b1, fl: 1'b0, ph: 3'(nk), cnt: 4'(nc), p1: lp1[nk], p2: lp2[nk]});
                pk = nk; pc = nc;
            end

        do_reset("reset_initial");
        for (int i = 0; i < vq.size(); i++) begin
            if (i == 32) do_reset("reset_before_slow");
            v = vq[i];
            step(v.tk, v.fl, 1'b0, 1'b1);
            chk($sformatf("vec%0d", i), v.ph, v.cnt, v.p1, v.p2, 1'b0);
        end

        // reset in P1_YELLOW count 2, with tick also high
        do_reset("reset_seq2");
        ticks(28, 1'b0);
        chk("p1y_cnt2", 3'd4, 4'd2, 3'b010, 3'b100, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_midphase", 3'd0, 4'd0, 3'b100, 3'b001, 1'b0);

        // flash from P1_GREEN count 5
        do_reset("reset_seq3");
        ticks(21, 1'b0);
        chk("p1g_cnt5", 3'd3, 4'd5, 3'b001, 3'b100, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("flash_no_tick", 3'd3, 4'd5, 3'b001, 3'b100, 1'b0);
        ticks(1, 1'b1);
        chk("flash_enter", 3'd6, 4'd0, 3'b010, 3'b010, 1'b0);
        ticks(1, 1'b1);
        chk("flash_off", 3'd6, 4'd1, 3'b000, 3'b000, 1'b0);
        ticks(1, 1'b1);
        chk("flash_on", 3'd6, 4'd2, 3'b010, 3'b010, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("flash_hold", 3'd6, 4'd2, 3'b010, 3'b010, 1'b0);
        ticks(13, 1'b1);
        chk("flash_cnt15", 3'd6, 4'd15, 3'b000, 3'b000, 1'b0);
        ticks(1, 1'b1);
        chk("flash_wrap", 3'd6, 4'd0, 3'b010, 3'b010, 1'b0);
        ticks(1, 1'b0);
        chk("flash_exit", 3'd5, 4'd0, 3'b100, 3'b100, 1'b0);
        ticks(1, 1'b0);
        chk("clrb_cnt1", 3'd5, 4'd1, 3'b100, 3'b100, 1'b0);
        ticks(1, 1'b0);
        chk("resume_p2g", 3'd0, 4'd0, 3'b100, 3'b001, 1'b0);

        // pedestrian request at P2_GREEN count 0
        do_reset("reset_seq4");
        step(1'b0, 1'b0, 1'b1, 1'b1);
        ticks(3, 1'b0);
`ifdef TRAFFIC_PED_REQ_EN
        chk("ped_trunc", 3'd1, 4'd0, 3'b100, 3'b010, 1'b0);
        ticks(4, 1'b0);
        chk("ped_walk_on", 3'd2, 4'd0, 3'b100, 3'b100, 1'b1);
        ticks(1, 1'b0);
        chk("ped_walk_hold", 3'd2, 4'd1, 3'b100, 3'b100, 1'b1);
        ticks(1, 1'b0);
        chk("ped_walk_off", 3'd3, 4'd0, 3'b001, 3'b100, 1'b0);
        ticks(9, 1'b0);
        chk("ped_next_full", 3'd3, 4'd9, 3'b001, 3'b100, 1'b0);
`else
        chk("ped_ignored", 3'd0, 4'd3, 3'b100, 3'b001, 1'b0);
        ticks(7, 1'b0);
        chk("ped_full_green", 3'd1, 4'd0, 3'b100, 3'b010, 1'b0);
        ticks(4, 1'b0);
        chk("ped_no_walk", 3'd2, 4'd0, 3'b100, 3'b100, 1'b0);
`endif

        // ped_req and flash on the same tick
        do_reset("reset_seq5");
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("pf_flash", 3'd6, 4'd0, 3'b010, 3'b010, 1'b0);
        ticks(1, 1'b0);
        chk("pf_exit", 3'd5, 4'd0, 3'b100, 3'b100, 1'b0);
        ticks(2, 1'b0);
        chk("pf_p2g", 3'd0, 4'd0, 3'b100, 3'b001, 1'b0);
        ticks(9, 1'b0);
        chk("pf_green9", 3'd0, 4'd9, 3'b100, 3'b001, 1'b0);
        ticks(1, 1'b0);
        chk("pf_yellow", 3'd1, 4'd0, 3'b100, 3'b010, 1'b0);
        ticks(4, 1'b0);
        chk("pf_clr_nowalk", 3'd2, 4'd0, 3'b100, 3'b100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
